tick_edge_monitor: RTL and testbench

Fast-domain monitor for the divided tick clock produced by the design's clock dividers. Synchronizes `divided_clk` into the `clk_in` domain, emits single-cycle rise/fall strobes for downstream logic that must stay on `clk_in`, measures the tick period in `clk_in` cycles, and flags loss of the tick. Sits between each divider output and the keypad-scan, debounce and display logic of the lock.

---
 rtl/lock_pkg.sv | 13 +
 rtl/tick_edge_monitor_if.sv | 32 +++
 rtl/bit_synchronizer.sv | 23 ++
 rtl/tick_edge_monitor.sv | 116 +++++++++++
 tb/tb_tick_edge_monitor.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared types for the lock's tick monitoring logic.
// Holds the monitor FSM states and the default counter width.
package lock_pkg;

    localparam int LOCK_CNT_W = 27;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOST
    } mon_state_e;

endpackage

// File: rtl/tick_edge_monitor_if.sv
// Bundle between a divider tick and its fast-domain monitor.
// master = monitor side, slave = downstream consumer side.
interface tick_edge_monitor_if
    import lock_pkg::*;
#(
    parameter int CNT_W = LOCK_CNT_W
);
    logic             divided_clk;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period_cnt;
    logic             period_valid;
    logic             tick_lost;

    modport master (
        input  divided_clk,
        output rise_pulse,
        output fall_pulse,
        output period_cnt,
        output period_valid,
        output tick_lost
    );

    modport slave (
        output divided_clk,
        input  rise_pulse,
        input  fall_pulse,
        input  period_cnt,
        input  period_valid,
        input  tick_lost
    );
endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
// All stages clear to 0 on reset.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the async input through the synchronizer chain
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/tick_edge_monitor.sv
// Synchronizes a divider tick, emits edge strobes,
// measures rise-to-rise period and flags a lost tick.
module tick_edge_monitor
    import lock_pkg::*;
#(
    parameter int             CNT_W       = LOCK_CNT_W,
    parameter int             SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(400000)
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    tick_edge_monitor_if.master   mon
);
    logic             w_sync;
    logic             w_rise;
    logic             w_fall;
    logic             w_at_limit;
    logic             w_publish;
    mon_state_e       w_state_nxt;

    logic             r_prev;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_period_cnt;
    logic             r_period_valid;
    mon_state_e       r_state;

    bit_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .i_d   (mon.divided_clk),
        .o_q   (w_sync)
    );

    assign w_rise     = w_sync & ~r_prev;
    assign w_fall     = ~w_sync & r_prev;
    assign w_at_limit = (r_run_cnt == TIMEOUT);

    // Edge history flop and registered edge strobes
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= w_sync;
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    // Cycles since last rise; restarts at 1, saturates at TIMEOUT
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
        end else if (w_rise) begin
            r_run_cnt <= CNT_W'(1);
        end else if (!w_at_limit) begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    // Next state and publish decision; a rise beats the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_publish   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = MEASURE;
                end else if (w_at_limit) begin
                    w_state_nxt = LOST;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_publish = 1'b1;
                end else if (w_at_limit) begin
                    w_state_nxt = LOST;
                end
            end
            LOST: begin
                if (w_rise) begin
                    w_state_nxt = MEASURE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register plus published period and its strobe
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_period_valid <= 1'b0;
            r_period_cnt   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_period_valid <= w_publish;
            if (w_publish) begin
                r_period_cnt <= r_run_cnt;
            end
        end
    end

    assign mon.rise_pulse   = r_rise;
    assign mon.fall_pulse   = r_fall;
    assign mon.period_cnt   = r_period_cnt;
    assign mon.period_valid = r_period_valid;
    assign mon.tick_lost    = (r_state == LOST);
endmodule

// File: tb/tb_tick_edge_monitor.sv
// Bench for tick_edge_monitor: directed and random tick
// waveforms checked against an event-level reference model.
module tb_tick_edge_monitor;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tick_edge_monitor_if #(.CNT_W(27)) if_a ();
    tick_edge_monitor_if #(.CNT_W(27)) if_b ();
    tick_edge_monitor_if #(.CNT_W(27)) if_c ();

    tick_edge_monitor #(
        .CNT_W(27), .SYNC_STAGES(2), .TIMEOUT(27'd50)
    ) dut_a (
        .clk_in(clk), .rst_n(rst_a), .mon(if_a.master)
    );

    tick_edge_monitor #(
        .CNT_W(27), .SYNC_STAGES(3), .TIMEOUT(27'd20)
    ) dut_b (
        .clk_in(clk), .rst_n(rst_b), .mon(if_b.master)
    );

    tick_edge_monitor #(
        .CNT_W(27), .SYNC_STAGES(2), .TIMEOUT(27'd400000)
    ) dut_c (
        .clk_in(clk), .rst_n(rst_c), .mon(if_c.master)
    );

    // reference model state for the instance under test
    int          cur;
    int          S;
    int          T;
    logic        hist[$];
    int          e;
    int          ref_e;
    bit          seen;
    bit          lost;
    logic [26:0] pc_exp;

    function automatic logic in_at(int x);
        if (x < 1 || x > hist.size()) return 1'b0;
        return hist[x-1];
    endfunction

    task automatic check(string tag, logic [26:0] obs,
                         logic [26:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst=%0d edge=%0d: observed=%0d expected=%0d",
                   tag, cur, e, obs, exp);
        end
    endtask

    task automatic read_outs(output logic rp, output logic fp,
                             output logic pv, output logic tl,
                             output logic [26:0] pc);
        case (cur)
            0: begin
                rp = if_a.rise_pulse;  fp = if_a.fall_pulse;
                pv = if_a.period_valid; tl = if_a.tick_lost;
                pc = if_a.period_cnt;
            end
            1: begin
                rp = if_b.rise_pulse;  fp = if_b.fall_pulse;
                pv = if_b.period_valid; tl = if_b.tick_lost;
                pc = if_b.period_cnt;
            end
            default: begin
                rp = if_c.rise_pulse;  fp = if_c.fall_pulse;
                pv = if_c.period_valid; tl = if_c.tick_lost;
                pc = if_c.period_cnt;
            end
        endcase
    endtask

    task automatic set_in(logic v);
        case (cur)
            0:       if_a.divided_clk = v;
            1:       if_b.divided_clk = v;
            default: if_c.divided_clk = v;
        endcase
    endtask

    task automatic set_rst(logic v);
        case (cur)
            0:       rst_a = v;
            1:       rst_b = v;
            default: rst_c = v;
        endcase
    endtask

    task automatic model_reset();
        hist.delete();
        e      = 0;
        ref_e  = 1;
        seen   = 1'b0;
        lost   = 1'b0;
        pc_exp = '0;
    endtask

    task automatic check_zero(string tag);
        logic rp, fp, pv, tl;
        logic [26:0] pc;
        read_outs(rp, fp, pv, tl, pc);
        check({tag, "_rise"}, 27'(rp), 27'd0);
        check({tag, "_fall"}, 27'(fp), 27'd0);
        check({tag, "_valid"}, 27'(pv), 27'd0);
        check({tag, "_lost"}, 27'(tl), 27'd0);
        check({tag, "_period"}, pc, 27'd0);
    endtask

    // one clk_in edge: drive, advance, model, compare
    task automatic step(logic v);
        logic rp, fp, pv, tl;
        logic [26:0] pc;
        logic exp_r, exp_f, exp_v;
        set_in(v);
        @(posedge clk);
        #1;
        e++;
        hist.push_back(v);
        exp_r = in_at(e - S) & ~in_at(e - S - 1);
        exp_f = ~in_at(e - S) & in_at(e - S - 1);
        exp_v = 1'b0;
        if (exp_r) begin
            if (seen && !lost) begin
                exp_v  = 1'b1;
                pc_exp = 27'(e - ref_e);
            end
            seen  = 1'b1;
            lost  = 1'b0;
            ref_e = e;
        end else if (!lost && (e - ref_e) == T) begin
            lost = 1'b1;
        end
        read_outs(rp, fp, pv, tl, pc);
        check("rise_pulse", 27'(rp), 27'(exp_r));
        check("fall_pulse", 27'(fp), 27'(exp_f));
        check("period_valid", 27'(pv), 27'(exp_v));
        check("tick_lost", 27'(tl), 27'(lost));
        check("period_cnt", pc, pc_exp);
    endtask

    task automatic run(logic v, int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic start(int inst, int s, int t);
        cur = inst;
        S   = s;
        T   = t;
        set_in(1'b0);
        set_rst(1'b0);
        #2;
        check_zero("reset");
        set_rst(1'b1);
        model_reset();
    endtask

    task automatic random_run(int segs, int lo_max, int hi_lo,
                              int hi_hi);
        logic v;
        int   len;
        v = 1'b1;
        for (int i = 0; i < segs; i++) begin
            if ($urandom_range(0, 7) == 0)
                len = $urandom_range(hi_lo, hi_hi);
            else
                len = $urandom_range(1, lo_max);
            run(v, len);
            v = ~v;
        end
    endtask

    initial begin
        int n;
        logic rp, fp, pv, tl;
        logic [26:0] pc;
        if_a.divided_clk = 1'b0;
        if_b.divided_clk = 1'b0;
        if_c.divided_clk = 1'b0;

        // instance A: SYNC_STAGES=2, TIMEOUT=50
        start(0, 2, 50);
        run(1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            run(1'b1, 5);
            run(1'b0, 5);
        end
        read_outs(rp, fp, pv, tl, pc);
        check("sq10_period", pc, 27'd10);
        run(1'b0, 70);
        read_outs(rp, fp, pv, tl, pc);
        check("lost_level", 27'(tl), 27'd1);
        check("lost_holds_period", pc, 27'd10);
        run(1'b1, 5);
        run(1'b0, 7);
        run(1'b1, 5);
        run(1'b0, 5);
        read_outs(rp, fp, pv, tl, pc);
        check("recover_period", pc, 27'd12);
        random_run(40, 25, 45, 60);
        run(1'b0, 4);
        run(1'b1, 3);
        rst_a = 1'b0;
        #1;
        check_zero("midreset");
        #1;
        rst_a = 1'b1;
        model_reset();
        run(1'b1, 8);
        run(1'b0, 4);

        // instance B: SYNC_STAGES=3, TIMEOUT=20
        start(1, 3, 20);
        run(1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            run(1'b1, 10);
            run(1'b0, 10);
        end
        read_outs(rp, fp, pv, tl, pc);
        check("boundary_period", pc, 27'd20);
        check("boundary_no_lost", 27'(tl), 27'd0);
        run(1'b1, 10);
        run(1'b0, 11);
        run(1'b1, 10);
        run(1'b0, 10);
        random_run(30, 12, 18, 26);
        run(1'b0, 30);

        // instance C: divider model, default TIMEOUT
        start(2, 2, 400000);
        for (int k = 0; k < 2; k++) begin
            n = $urandom_range(40, 120);
            for (int i = 0; i < 3; i++) begin
                run(1'b1, n + 1);
                run(1'b0, n + 1);
            end
            run(1'b1, 3);
            read_outs(rp, fp, pv, tl, pc);
            check("divider_period", pc, 27'(2 * (n + 1)));
            check("divider_no_lost", 27'(tl), 27'd0);
            run(1'b1, n - 2);
            run(1'b0, n + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
